log_unit_pipe: RTL and testbench

LOG_UNIT_PIPE -- requirements
Module: log_unit_pipe

---
 rtl/log_unit_pipe.sv | 168 ++++++++++++++++
 tb/tb_log_unit_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_unit_pipe.sv
// rtl/log_unit_pipe.sv - seven-stage -2*ln(u) pipeline with an external coefficient ROM
// Range reduction, 2nd-order Horner polynomial and ln2 reconstruction under one global advance.
module log_unit_pipe #(
   parameter int IN_W  = 48,
   parameter int IDX_W = 8,
   parameter int OUT_W = 31,
   parameter int C2_W  = 13,
   parameter int C1_W  = 22,
   parameter int C0_W  = 30
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IN_W-1:0]             u0,
   output logic [IDX_W-1:0]            coef_idx,
   output logic                        coef_en,
   input  logic [C2_W+C1_W+C0_W-1:0]   coef_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            e,
   output logic                        e_sat
);

   localparam int F    = IN_W - IDX_W;
   localparam int EX_W = $clog2(IN_W + 2);
   localparam int P1_W = C2_W + F;
   localparam int S1_W = C1_W + 1;
   localparam int P2_W = S1_W + F;
   localparam int Y_W  = C0_W + 2;
   localparam int D_W  = 37;
   localparam int E2_W = D_W + 1;
   localparam int SH1  = F + C2_W - C1_W;
   localparam int SH2  = F + C1_W - C0_W;
   localparam int ESH  = 30 - (OUT_W - 7);
   localparam logic [29:0] LN2 = 30'h2C5C85FD;

   logic                w_adv;
   logic [EX_W-1:0]     w_lz;
   logic [EX_W-1:0]     w_ex;
   logic [IN_W-1:0]     w_x;
   logic                w_zero;
   logic [C2_W-1:0]     w_c2;
   logic [C1_W-1:0]     w_c1;
   logic [C0_W-1:0]     w_c0;
   logic [P1_W-1:0]     w_p1;
   logic [S1_W-1:0]     w_s1;
   logic [P2_W-1:0]     w_p2;
   logic [D_W-1:0]      w_k;
   logic [Y_W-1:0]      w_y;
   logic [D_W-1:0]      w_d;
   logic [E2_W-1:0]     w_e2;
   logic                w_ovf;

   logic                r_v1, r_v2, r_v3, r_v4, r_v5, r_v6, r_v7;
   logic                r_z1, r_z2, r_z3, r_z4, r_z5, r_z6;
   logic [EX_W-1:0]     r_ex1, r_ex2, r_ex3, r_ex4;
   logic [F-1:0]        r_xf1, r_xf2, r_xf3, r_xf4;
   logic [IDX_W-1:0]    r_idx;
   logic [C1_W-1:0]     r_c1_3;
   logic [C0_W-1:0]     r_c0_3, r_c0_4, r_c0_5;
   logic [P1_W-1:0]     r_p1_3;
   logic [S1_W-1:0]     r_s1_4;
   logic [P2_W-1:0]     r_p2_5;
   logic [D_W-1:0]      r_k5;
   logic [D_W-1:0]      r_d6;
   logic [OUT_W-1:0]    r_e;
   logic                r_sat;

   assign w_adv     = out_ready | ~r_v7;
   assign in_ready  = w_adv;
   assign coef_en   = w_adv;
   assign coef_idx  = r_idx;
   assign out_valid = r_v7;
   assign e         = r_e;
   assign e_sat     = r_sat;

   // Highest set bit wins; an all-zero input reports IN_W leading zeros.
   always_comb begin
      w_lz = EX_W'(IN_W);
      for (int i = 0; i < IN_W; i++) begin
         if (u0[i]) w_lz = EX_W'(IN_W - 1 - i);
      end
   end

   assign w_ex   = w_lz + EX_W'(1);
   assign w_x    = u0 << w_ex;
   assign w_zero = ~|u0;

   assign w_c2 = coef_in[C2_W+C1_W+C0_W-1 -: C2_W];
   assign w_c1 = coef_in[C1_W+C0_W-1 -: C1_W];
   assign w_c0 = coef_in[C0_W-1:0];

   assign w_p1 = P1_W'(w_c2) * P1_W'(r_xf2);
   assign w_s1 = S1_W'(r_c1_3) + S1_W'(r_p1_3 >> SH1);
   assign w_p2 = P2_W'(r_s1_4) * P2_W'(r_xf4);
   assign w_k  = D_W'(r_ex4) * D_W'(LN2);
   assign w_y  = Y_W'(r_c0_5) + Y_W'(r_p2_5 >> SH2);
   assign w_d  = r_k5 - D_W'(w_y);

   // Doubling folds into the shift; anything above the output field means saturation.
   assign w_e2  = {r_d6, 1'b0} >> ESH;
   assign w_ovf = |w_e2[E2_W-1:OUT_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0;
         r_v5 <= 1'b0; r_v6 <= 1'b0; r_v7 <= 1'b0;
         r_z1 <= 1'b0; r_z2 <= 1'b0; r_z3 <= 1'b0;
         r_z4 <= 1'b0; r_z5 <= 1'b0; r_z6 <= 1'b0;
         r_ex1 <= '0; r_ex2 <= '0; r_ex3 <= '0; r_ex4 <= '0;
         r_xf1 <= '0; r_xf2 <= '0; r_xf3 <= '0; r_xf4 <= '0;
         r_idx <= '0;
         r_c1_3 <= '0; r_c0_3 <= '0; r_c0_4 <= '0; r_c0_5 <= '0;
         r_p1_3 <= '0; r_s1_4 <= '0; r_p2_5 <= '0; r_k5 <= '0;
         r_d6  <= '0;
         r_e   <= '0;
         r_sat <= 1'b0;
      end else if (w_adv) begin
         r_v1  <= in_valid;
         r_z1  <= w_zero;
         r_ex1 <= w_ex;
         r_idx <= w_x[IN_W-1 -: IDX_W];
         r_xf1 <= w_x[F-1:0];

         r_v2  <= r_v1;
         r_z2  <= r_z1;
         r_ex2 <= r_ex1;
         r_xf2 <= r_xf1;

         // ROM output now belongs to the sample leaving R2.
         r_v3   <= r_v2;
         r_z3   <= r_z2;
         r_ex3  <= r_ex2;
         r_xf3  <= r_xf2;
         r_c1_3 <= w_c1;
         r_c0_3 <= w_c0;
         r_p1_3 <= w_p1;

         r_v4   <= r_v3;
         r_z4   <= r_z3;
         r_ex4  <= r_ex3;
         r_xf4  <= r_xf3;
         r_c0_4 <= r_c0_3;
         r_s1_4 <= w_s1;

         r_v5   <= r_v4;
         r_z5   <= r_z4;
         r_c0_5 <= r_c0_4;
         r_p2_5 <= w_p2;
         r_k5   <= w_k;

         r_v6 <= r_v5;
         r_z6 <= r_z5;
         r_d6 <= w_d;

         r_v7 <= r_v6;
         if (r_z6 || w_ovf) begin
            r_e   <= '1;
            r_sat <= 1'b1;
         end else begin
            r_e   <= w_e2[OUT_W-1:0];
            r_sat <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_log_unit_pipe.sv
// tb/tb_log_unit_pipe.sv - directed and randomized checks of log_unit_pipe against an arithmetic model
module tb_log_unit_pipe;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [47:0]   u0;
   logic [7:0]    coef_idx;
   logic          coef_en;
   logic [64:0]   coef_in = '0;
   logic          out_valid;
   logic          out_ready;
   logic [30:0]   e;
   logic          e_sat;

   always #5 clk = ~clk;

   log_unit_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .u0        (u0),
      .coef_idx  (coef_idx),
      .coef_en   (coef_en),
      .coef_in   (coef_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .e         (e),
      .e_sat     (e_sat)
   );

   logic [64:0] rom [256];

   always @(posedge clk) begin
      if (coef_en) coef_in <= rom[coef_idx];
   end

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_out    = 0;
   logic [31:0] exp_q[$];
   logic        obs_valid, obs_ready, obs_en, obs_sat, obs_fire_in;
   logic [30:0] obs_e;
   logic        hold_pending = 1'b0;
   logic [30:0] hold_e;
   logic        hold_sat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks = n_checks + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Result as {sat, e}: e = -2*ln(u) built from leading-one normalisation and the table polynomial.
   function automatic logic [31:0] model(input logic [47:0] u);
      logic [63:0] uu, m, xf, c2, c1, c0, p1, s1, p2, y, k, d, e2;
      logic [64:0] cw;
      int          ex;
      int          idx;
      if (u == 48'd0) return {1'b1, 31'h7FFF_FFFF};
      uu = {16'd0, u};
      ex = 1;
      while ((uu << ex) < (64'd1 << 48)) ex++;
      m   = (uu << ex) - (64'd1 << 48);
      idx = int'(m >> 40);
      xf  = m & ((64'd1 << 40) - 64'd1);
      cw  = rom[idx];
      c2  = 64'(cw[64:52]);
      c1  = 64'(cw[51:30]);
      c0  = 64'(cw[29:0]);
      p1  = c2 * xf;
      s1  = c1 + (p1 >> 31);
      p2  = s1 * xf;
      y   = c0 + (p2 >> 32);
      k   = 64'(ex) * 64'h2C5C_85FD;
      d   = k - y;
      e2  = (d * 64'd2) >> 6;
      if (e2 > 64'h7FFF_FFFF) return {1'b1, 31'h7FFF_FFFF};
      return {1'b0, e2[30:0]};
   endfunction

   function automatic logic [47:0] rand_u();
      logic [63:0] t;
      t = {$urandom, $urandom};
      t = (t & 64'hFFFF_FFFF_FFFF) >> $urandom_range(0, 47);
      if ($urandom_range(0, 15) == 0) t = 64'd0;
      return t[47:0];
   endfunction

   // One cycle: drive at the falling edge, observe 1 time unit later, then advance to the next falling edge.
   task automatic step(input logic v, input logic [47:0] u, input logic ordy);
      logic [31:0] expd;
      in_valid  = v;
      u0        = u;
      out_ready = ordy;
      #1;
      obs_valid   = out_valid;
      obs_e       = e;
      obs_sat     = e_sat;
      obs_ready   = in_ready;
      obs_en      = coef_en;
      obs_fire_in = in_valid & in_ready;
      if (hold_pending) begin
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_e", 64'(e), 64'(hold_e));
         chk("stall_sat", 64'(e_sat), 64'(hold_sat));
      end
      hold_pending = out_valid & ~out_ready;
      hold_e       = e;
      hold_sat     = e_sat;
      if (obs_fire_in) exp_q.push_back(model(u));
      if (out_valid && out_ready) begin
         n_out = n_out + 1;
         if (exp_q.size() == 0) begin
            chk("spurious_output_qsize", 64'(exp_q.size()), 64'd1);
         end else begin
            expd = exp_q.pop_front();
            chk("e", 64'(e), 64'(expd[30:0]));
            chk("e_sat", 64'(e_sat), 64'(expd[31]));
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_lat(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 48'd0, 1'b1);
         if (obs_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   int          lat;
   int          sent;
   int          base_out;
   int          fires;
   logic        have;
   logic [47:0] u;
   logic [31:0] mres;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      u0        = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rom[i] = {13'($urandom_range(0, 2047)), 22'($urandom_range(0, 1048575)),
                   30'($urandom_range(0, 134217727))};
      end
      rom[0] = '0;

      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_e", 64'(e), 64'd0);
      chk("rst_e_sat", 64'(e_sat), 64'd0);
      chk("rst_coef_idx", 64'(coef_idx), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_coef_en", 64'(coef_en), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 48'h8000_0000_0000, 1'b1);
      wait_lat(lat);
      chk("lat_half", 64'(lat), 64'd7);
      chk("e_half", 64'(obs_e), 64'h0162_E42F);
      chk("sat_half", 64'(obs_sat), 64'd0);

      step(1'b1, 48'd0, 1'b1);
      wait_lat(lat);
      chk("lat_zero", 64'(lat), 64'd7);
      chk("e_zero", 64'(obs_e), 64'h7FFF_FFFF);
      chk("sat_zero", 64'(obs_sat), 64'd1);

      step(1'b1, 48'd1, 1'b1);
      wait_lat(lat);
      mres = model(48'd1);
      chk("lat_one", 64'(lat), 64'd7);
      chk("e_one", 64'(obs_e), 64'(mres[30:0]));
      chk("sat_one", 64'(obs_sat), 64'd0);

      // Back-to-back random stream, random backpressure.
      base_out = n_out;
      sent = 0;
      have = 1'b0;
      for (int g = 0; g < 2000 && sent < 64; g++) begin
         if (!have) begin
            u = rand_u();
            have = 1'b1;
         end
         step(1'b1, u, 1'($urandom_range(0, 1)));
         if (obs_fire_in) begin
            sent = sent + 1;
            have = 1'b0;
         end
      end
      chk("stream_sent", 64'(sent), 64'd64);
      for (int g = 0; g < 40 && exp_q.size() > 0; g++) step(1'b0, 48'd0, 1'b1);
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      chk("stream_count", 64'(n_out - base_out), 64'd64);

      // Random bubbles and backpressure.
      base_out = n_out;
      sent = 0;
      have = 1'b0;
      for (int g = 0; g < 2000 && sent < 32; g++) begin
         if (!have) begin
            u = rand_u();
            have = 1'b1;
         end
         step(1'($urandom_range(0, 1)), u, 1'($urandom_range(0, 1)));
         if (obs_fire_in) begin
            sent = sent + 1;
            have = 1'b0;
         end
      end
      for (int g = 0; g < 40 && exp_q.size() > 0; g++) step(1'b0, 48'd0, 1'b1);
      chk("bubble_count", 64'(n_out - base_out), 64'd32);

      // Fill all seven stages, stall ten cycles, then release.
      fires = 0;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, rand_u(), 1'b0);
         if (obs_fire_in) fires = fires + 1;
      end
      chk("fill_fires", 64'(fires), 64'd7);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, rand_u(), 1'b0);
         chk("stall_in_ready", 64'(obs_ready), 64'd0);
         chk("stall_coef_en", 64'(obs_en), 64'd0);
      end
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 48'd0, 1'b1);
         chk("release_valid", 64'(obs_valid), 64'd1);
      end
      step(1'b0, 48'd0, 1'b1);
      chk("release_end", 64'(obs_valid), 64'd0);

      // Reset with samples in flight.
      for (int i = 0; i < 4; i++) step(1'b1, rand_u(), 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_flight_valid", 64'(out_valid), 64'd0);
      chk("rst_flight_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      hold_pending = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      u = rand_u();
      mres = model(u);
      step(1'b1, u, 1'b1);
      wait_lat(lat);
      chk("lat_after_rst", 64'(lat), 64'd7);
      chk("e_after_rst", 64'(obs_e), 64'(mres[30:0]));
      chk("q_after_rst", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
